unsigned_seq_divider_16by8: RTL and testbench

//   Iterative unsigned divider: z / y -> quotient q, remainder r, one restoring step per cycle.

---
 rtl/unsigned_div_pkg.sv | 29 ++
 rtl/div_restore_step.sv | 23 ++
 rtl/unsigned_seq_divider_16by8.sv | 119 +++++++++++
 tb/tb_unsigned_seq_divider_16by8.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/unsigned_div_pkg.sv
// Shared types and sizing for the unsigned sequential divider.
// APPROX_DIV_TRUNC_EN selects the truncated-iteration variant.
package unsigned_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  localparam int WN_DEF    = 16;
  localparam int WD_DEF    = 8;
  localparam int TRUNC_DEF = 2;

`ifdef APPROX_DIV_TRUNC_EN
  localparam bit APPROX = 1'b1;
`else
  localparam bit APPROX = 1'b0;
`endif

  function automatic int nit(
    input int wn,
    input int trunc,
    input bit approx
  );
    return approx ? wn - trunc : wn;
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract.
module div_restore_step #(
  parameter int WD = 8
) (
  input  logic [WD:0]   p_i,
  input  logic          bit_i,
  input  logic [WD-1:0] y_i,
  output logic [WD:0]   p_next_o,
  output logic          q_bit_o
);

  logic [WD:0] sh;
  logic [WD:0] dv;
  logic        unused_msb;

  // Top bit of P is always clear between steps, so it is shifted out.
  assign unused_msb = p_i[WD];
  assign sh         = {p_i[WD-1:0], bit_i};
  assign dv         = {1'b0, y_i};
  assign q_bit_o    = (sh >= dv);
  assign p_next_o   = q_bit_o ? sh - dv : sh;

endmodule

// File: rtl/unsigned_seq_divider_16by8.sv
// Iterative unsigned divider z / y, one restoring step per cycle.
// APPROX_DIV_TRUNC_EN skips the TRUNC low quotient iterations.
module unsigned_seq_divider_16by8
  import unsigned_div_pkg::*;
#(
  parameter int WN    = WN_DEF,
  parameter int WD    = WD_DEF,
  parameter int TRUNC = TRUNC_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WN-1:0] z,
  input  logic [WD-1:0] y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WN-1:0] q,
  output logic [WD-1:0] r,
  output logic          div_zero
);

  localparam int NIT = nit(WN, TRUNC, APPROX);
  localparam int CW  = $clog2(WN);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WN-1:0] qsh_q, qsh_d;
  logic [WD-1:0] dvs_q, dvs_d;
  logic [WD:0]   p_q, p_d;
  logic          dz_q, dz_d;

  logic [WD:0]   p_nx;
  logic          qb;

  div_restore_step #(.WD(WD)) u_step (
    .p_i      (p_q),
    .bit_i    (qsh_q[WN-1]),
    .y_i      (dvs_q),
    .p_next_o (p_nx),
    .q_bit_o  (qb)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    qsh_d   = qsh_q;
    dvs_d   = dvs_q;
    p_d     = p_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = BUSY;
          cnt_d   = '0;
          dvs_d   = y;
          dz_d    = (y == '0);
          if (y == '0) begin
            qsh_d = '1;
            p_d   = {1'b0, z[WD-1:0]};
          end else begin
            // Truncated mode still loads all of z: only the top NIT
            // bits are ever shifted into P, i.e. z >> TRUNC.
            qsh_d = z;
            p_d   = '0;
          end
        end
      end
      BUSY: begin
        if (dz_q) begin
          state_d = DONE;
        end else begin
          p_d   = p_nx;
          qsh_d = {qsh_q[WN-2:0], qb};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(NIT - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      qsh_q   <= '0;
      dvs_q   <= '0;
      p_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      qsh_q   <= qsh_d;
      dvs_q   <= dvs_d;
      p_q     <= p_d;
      dz_q    <= dz_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign r         = p_q[WD-1:0];
  assign div_zero  = dz_q;

`ifdef APPROX_DIV_TRUNC_EN
  assign q = dz_q ? '1 : {qsh_q[NIT-1:0], {TRUNC{1'b0}}};
`else
  assign q = dz_q ? '1 : qsh_q;
`endif

endmodule

// File: tb/tb_unsigned_seq_divider_16by8.sv
// Self-checking bench for unsigned_seq_divider_16by8 (directed + random).
// Honours APPROX_DIV_TRUNC_EN in its reference model.
module tb_unsigned_seq_divider_16by8;

  localparam int T = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] z;
  logic [7:0]  y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] q;
  logic [7:0]  r;
  logic        div_zero;

  int n_cmp = 0;
  int n_err = 0;

  unsigned_seq_divider_16by8 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .z         (z),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .r         (r),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, optionally on z >> T.
  task automatic model(input int zz, input int yy,
                       output int eq, output int er,
                       output int edz, output int lat);
`ifdef APPROX_DIV_TRUNC_EN
    int zt = zz >> T;
    lat = 16 - T + 1;
`else
    int zt = zz;
    lat = 17;
`endif
    if (yy == 0) begin
      eq  = 16'hFFFF;
      er  = zz % 256;
      edz = 1;
      lat = 2;
    end else begin
      eq  = (zt / yy) << (16 - zt == zz ? 0 : 0);
`ifdef APPROX_DIV_TRUNC_EN
      eq  = (zt / yy) << T;
`else
      eq  = zt / yy;
`endif
      er  = zt % yy;
      edz = 0;
    end
  endtask

  task automatic start_op(input logic [15:0] zz, input logic [7:0] yy,
                          input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    z        = zz;
    y        = yy;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Waits for out_valid (accept edge counted as edge 1) and checks result.
  task automatic wait_check(input logic [15:0] zz, input logic [7:0] yy,
                            input string tag);
    int eq, er, edz, lat;
    int n = 1;
    model(int'(zz), int'(yy), eq, er, edz, lat);
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(lat));
    check({tag, "_q"}, 32'(q), 32'(eq));
    check({tag, "_r"}, 32'(r), 32'(er));
    check({tag, "_div_zero"}, 32'(div_zero), 32'(edz));
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_out_valid_clr"}, 32'(out_valid), 32'd0);
    check({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_div(input logic [15:0] zz, input logic [7:0] yy,
                         input string tag);
    start_op(zz, yy, tag);
    wait_check(zz, yy, tag);
    drain(tag);
  endtask

  initial begin
    logic [15:0] hq;
    logic [7:0]  hr;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    z         = '0;
    y         = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_q", 32'(q), 32'd0);
    check("rst_r", 32'(r), 32'd0);
    check("rst_div_zero", 32'(div_zero), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_div(16'd1000, 8'd7, "d1000_7");
    run_div(16'd65535, 8'd255, "dmax_255");
    run_div(16'd65535, 8'd1, "dmax_1");
    run_div(16'h1234, 8'd0, "dzero");
    run_div(16'd0, 8'd5, "dz0_5");
    run_div(16'd200, 8'd201, "dsmall");

    // Backpressure: result held, new operands ignored while stalled.
    start_op(16'd50000, 8'd13, "bp");
    wait_check(16'd50000, 8'd13, "bp");
    hq       = q;
    hr       = r;
    z        = 16'd7;
    y        = 8'd3;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold",
            32'({out_valid, in_ready, (q == hq), (r == hr)}),
            32'b1011);
    end
    in_valid = 1'b0;
    drain("bp");
    repeat (3) begin
      @(posedge clk);
      #1;
      check("bp_ignored", 32'({out_valid, in_ready}), 32'b01);
    end

    // Release and new request on the same edge: accept waits for IDLE.
    start_op(16'd999, 8'd10, "ovl");
    wait_check(16'd999, 8'd10, "ovl");
    z         = 16'd4321;
    y         = 8'd17;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("ovl_idle", 32'({out_valid, in_ready}), 32'b01);
    in_valid = 1'b0;
    run_div(16'd4321, 8'd17, "ovl2");

    // Reset in the middle of an iteration sequence.
    start_op(16'd1000, 8'd7, "rmid");
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rmid_state",
          32'({out_valid, in_ready, div_zero}), 32'b010);
    check("rmid_q", 32'(q), 32'd0);
    check("rmid_r", 32'(r), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rmid_no_valid", 32'(out_valid), 32'd0);
    run_div(16'd1000, 8'd7, "rmid_after");

    for (int i = 0; i < 40; i++) begin
      logic [15:0] rz;
      logic [7:0]  ry;
      rz = 16'($urandom);
      ry = (i % 8 == 3) ? 8'd0 : 8'($urandom);
      run_div(rz, ry, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
